// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, single-outstanding memory request FSM,
// and a 2-entry in-order {inst, pc} buffer feeding the downstream decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_req_addr;
  logic [31:0] r_buf_inst [2];
  logic [31:0] r_buf_pc   [2];
  logic [1:0]  r_count;
  logic [31:0] w_target;
  logic        w_hs;
  logic        w_push;
  logic        w_pop;

  // Outputs are forced to their reset values while reset is high, even on the
  // first reset cycle before the registers have been cleared.
  always_comb begin
    imem_req   = !reset && (r_state == S_FETCH) && (r_count != 2'd2);
    imem_addr  = reset ? RESET_PC : r_pc;
    inst_valid = !reset && (r_count != 2'd0);
    inst       = reset ? '0 : r_buf_inst[0];
    inst_pc    = reset ? '0 : r_buf_pc[0];
  end

  assign w_target = redirect_pc & 32'hFFFF_FFFC;
  assign w_hs     = imem_req & imem_ready;
  assign w_push   = (r_state == S_WAIT) && imem_rvalid && !redirect;
  assign w_pop    = inst_valid & inst_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (redirect) begin
      w_pc_nxt = w_target;
      case (r_state)
        S_FETCH: w_state_nxt = w_hs ? S_DISCARD : S_FETCH;
        S_WAIT,
        S_DISCARD: w_state_nxt = imem_rvalid ? S_FETCH : S_DISCARD;
        default: w_state_nxt = S_FETCH;
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_hs) begin
            w_state_nxt = S_WAIT;
            w_pc_nxt    = r_pc + 32'd4;
          end
        end
        S_WAIT,
        S_DISCARD: begin
          if (imem_rvalid) w_state_nxt = S_FETCH;
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_req_addr    <= RESET_PC;
      r_count       <= '0;
      r_buf_inst[0] <= '0;
      r_buf_inst[1] <= '0;
      r_buf_pc[0]   <= '0;
      r_buf_pc[1]   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_hs) r_req_addr <= r_pc;
      if (redirect) begin
        r_count <= '0;
      end else begin
        // Head stays put when the buffer drains so inst/inst_pc hold their value.
        case ({w_push, w_pop})
          2'b10: begin
            r_buf_inst[r_count[0]] <= imem_rdata;
            r_buf_pc[r_count[0]]   <= r_req_addr;
            r_count                <= r_count + 2'd1;
          end
          2'b01: begin
            if (r_count == 2'd2) begin
              r_buf_inst[0] <= r_buf_inst[1];
              r_buf_pc[0]   <= r_buf_pc[1];
            end
            r_count <= r_count - 2'd1;
          end
          2'b11: begin
            if (r_count == 2'd2) begin
              r_buf_inst[0] <= r_buf_inst[1];
              r_buf_pc[0]   <= r_buf_pc[1];
              r_buf_inst[1] <= imem_rdata;
              r_buf_pc[1]   <= r_req_addr;
            end else begin
              r_buf_inst[0] <= imem_rdata;
              r_buf_pc[0]   <= r_req_addr;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset (word aligned).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address; valid while imem_req=1.
REQ-006 imem_ready  input  1  memory accepts request this cycle (handshake = imem_req & imem_ready).
REQ-007 imem_rvalid  input  1  read data valid; in-order, at least 1 cycle after acceptance.
REQ-008 imem_rdata  input  32  instruction word returned with imem_rvalid.
REQ-009 redirect  input  1  branch/jump target override from downstream datapath.
REQ-010 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-011 inst_valid  output  1  buffer head holds a valid instruction.
REQ-012 inst  output  32  instruction at buffer head.
REQ-013 inst_pc  output  32  address of inst.
REQ-014 inst_ready  input  1  downstream consumes head when inst_valid & inst_ready.

Function
REQ-015 Shall hold a fetch PC register, a 2-entry in-order buffer of {inst, pc}, and an FSM with states FETCH, WAIT, DISCARD.
REQ-016 At most one request outstanding at any time.
REQ-017 FETCH: imem_req=1 iff buffer occupancy < 2; imem_addr = fetch PC; on handshake PC <= PC+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0) and go WAIT.
REQ-018 WAIT: imem_req=0; on imem_rvalid push {imem_rdata, address of the accepted request} into buffer, go FETCH.
REQ-019 DISCARD: imem_req=0; on imem_rvalid drop data, go FETCH.
REQ-020 imem_rvalid in FETCH state shall be ignored.
REQ-021 redirect has priority over all other events: buffer flushed (occupancy 0, inst_valid=0 next cycle), PC <= {redirect_pc[31:2], 2'b00}; next state DISCARD if in WAIT without imem_rvalid this cycle, else FETCH.
REQ-022 Redirect in FETCH coinciding with a handshake: request counts as accepted, next state DISCARD, PC <= redirect target (not PC+4).
REQ-023 Redirect in WAIT coinciding with imem_rvalid: returned data dropped, next state FETCH.
REQ-024 Buffer push and pop in same cycle: occupancy unchanged, order preserved; push to a full buffer cannot occur by REQ-017.
REQ-025 inst/inst_pc driven from buffer head; hold value when inst_valid=0 and held stable while inst_valid=1 & inst_ready=0.
REQ-026 Latency: with imem_ready=1 and rvalid 1 cycle after acceptance, instruction visible on inst_valid 2 cycles after its request cycle; steady-state throughput 1 instruction per 2 cycles.

Reset
REQ-027 While reset=1: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, buffer empty, PC=RESET_PC, state FETCH.
REQ-028 Reset mid-transaction abandons the outstanding request; a late imem_rvalid after reset is ignored per REQ-020.
REQ-029 First cycle after reset deasserts: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-030 Reset release, imem_ready=1, 1-cycle memory, inst_ready=1 -> inst_pc sequence 0x0,0x4,0x8 with inst matching memory, one every 2 cycles.
REQ-031 inst_ready=0 for 10 cycles -> exactly 2 instructions buffered, imem_req=0 afterwards, inst/inst_pc stable; release -> order 0x0,0x4, then 0x8.
REQ-032 redirect=1, redirect_pc=0x103 while in WAIT -> returned word dropped, next imem_addr=0x100, first inst_pc after redirect = 0x100.
REQ-033 redirect coincident with imem_rvalid -> data not buffered, next cycle imem_req=1 at target, inst_valid=0.
REQ-034 RESET_PC=32'hFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-035 reset asserted while in WAIT, rvalid arrives 1 cycle after reset release -> ignored, inst_valid stays 0, imem_addr=RESET_PC.
